// File: rtl/smm_cif_mac_accum.sv
// smm_cif_mac_accum: accumulates multiplier products, requantises, buffers.
// Optional SMM_CIF_ACC_ROUND_EN: round-half-up instead of truncation.
module smm_cif_mac_accum #(
  parameter int DIN_W = 64,
  parameter int ACC_W = 72,
  parameter int OUT_W = 32,
  parameter int SHIFT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIN_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int EW = ACC_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   sum;
  logic [EW-1:0]      ext;
  logic [EW-1:0]      q;
  logic [OUT_W-1:0]   res_data;
  logic               res_sat;
  logic               accept;
  logic               push;
  logic               pop;
  logic [OUT_W-1:0]   mem_data [2];
  logic               mem_sat  [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_last;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q == ACC) || (count != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_sat   = mem_sat[rd_ptr];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: open a dot-product on a non-last beat, close on last
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept && !in_last) state_d = ACC;
      end
      (state_q == ACC): begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a fresh dot-product starts from zero
  always_comb begin
    acc_base = '0;
    unique case (1'b1)
      (state_q == IDLE): acc_base = '0;
      (state_q == ACC):  acc_base = acc_q;
      default:           acc_base = '0;
    endcase
  end

  // Running sum and requantisation of the completed dot-product
  always_comb begin
    sum = acc_base + {{(ACC_W-DIN_W){1'b0}}, in_data};
`ifdef SMM_CIF_ACC_ROUND_EN
    ext = {1'b0, sum} + (EW'(1) << (SHIFT - 1));
`else
    ext = {1'b0, sum};
`endif
    q        = ext >> SHIFT;
    res_sat  = |q[EW-1:OUT_W];
    res_data = res_sat ? '1 : q[OUT_W-1:0];
  end

  // Accumulator: bubbles hold it, the last beat clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= in_last ? '0 : sum;
    end
  end

  // Two-entry result buffer storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_sat[0]  <= 1'b0;
      mem_sat[1]  <= 1'b0;
      wr_ptr      <= 1'b0;
    end else if (push) begin
      mem_data[wr_ptr] <= res_data;
      mem_sat[wr_ptr]  <= res_sat;
      wr_ptr           <= ~wr_ptr;
    end
  end

  // Buffer read pointer and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_smm_cif_mac_accum.sv
// tb_smm_cif_mac_accum: table vectors, corner sequences, random scoreboard.
// Expected values assume SHIFT=16, OUT_W=32, ACC_W=72.
module tb_smm_cif_mac_accum;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit rand_bp = 1'b0;

  logic [71:0] msum = '0;
  logic [32:0] sb[$];

  smm_cif_mac_accum dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [63:0] t[4];
    logic [31:0] ed;
    logic        es;
  } vec_t;

  function automatic logic [32:0] model(input logic [71:0] s);
    logic [72:0] t;
    t = {1'b0, s};
`ifdef SMM_CIF_ACC_ROUND_EN
    t = t + 73'h8000;
`endif
    t = t >> 16;
    if (|t[72:32]) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, t[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: model accepted beats, compare popped results
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_valid && in_ready) begin
        msum = msum + {8'h0, in_data};
        if (in_last) begin
          sb.push_back(model(msum));
          msum = '0;
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %0h want none", out_data);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          if ({out_sat, out_data} !== e) begin
            errors++;
            $display("FAIL sb_data: got %0h want %0h",
                     {out_sat, out_data}, e);
          end
        end
      end
    end
  end

  // Random consumer backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [63:0] d, input logic l);
    bit acc;
    int n;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{3, '{64'h10000, 64'h20000, 64'h30000, 64'h0}, 32'd6, 1'b0};
`ifdef SMM_CIF_ACC_ROUND_EN
    vt[1] = '{1, '{64'h18000, 64'h0, 64'h0, 64'h0}, 32'd2, 1'b0};
    vt[3] = '{1, '{64'hFFFF, 64'h0, 64'h0, 64'h0}, 32'd1, 1'b0};
    vt[4] = '{1, '{64'hFFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0},
              32'hFFFF_FFFF, 1'b1};
`else
    vt[1] = '{1, '{64'h18000, 64'h0, 64'h0, 64'h0}, 32'd1, 1'b0};
    vt[3] = '{1, '{64'hFFFF, 64'h0, 64'h0, 64'h0}, 32'd0, 1'b0};
    vt[4] = '{1, '{64'hFFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0},
              32'hFFFF_FFFF, 1'b0};
`endif
    vt[2] = '{2, '{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
                   64'h0, 64'h0}, 32'hFFFF_FFFF, 1'b1};
    vt[5] = '{1, '{64'h1_0000_0000_0000, 64'h0, 64'h0, 64'h0},
              32'hFFFF_FFFF, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    idle(2);

    // Table vectors, latency one cycle after the last beat
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vt[i].n; k++) begin
        send(vt[i].t[k], k == vt[i].n - 1);
        if (k == 0 && vt[i].n > 1) idle(1);
      end
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vt[i].ed));
      chk($sformatf("vec%0d_sat", i), 64'(out_sat), 64'(vt[i].es));
      drain();
    end

    // Backpressure: two buffered, third held
    out_ready = 1'b0;
    send(64'h10000, 1'b1);
    send(64'h20000, 1'b1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    in_data  = 64'h30000;
    in_last  = 1'b1;
    in_valid = 1'b1;
    idle(3);
    chk("bp_held_ready", 64'(in_ready), 64'd0);
    chk("bp_head_data", 64'(out_data), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_sb_depth", 64'(sb.size()), 64'd2);
    out_ready = 1'b1;
    send(64'h30000, 1'b1);
    drain();

    // Random bubbles and backpressure
    rand_bp = 1'b1;
    for (int d = 0; d < 1000; d++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        logic [63:0] v;
        v = {$urandom, $urandom};
        v = v >> $urandom_range(0, 40);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(v, k == len - 1);
      end
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a dot-product with a result buffered
    out_ready = 1'b0;
    send(64'h50000, 1'b1);
    send(64'h10000, 1'b0);
    send(64'h20000, 1'b0);
    chk("mid_valid_pre", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    sb.delete();
    msum = '0;
    idle(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(64'h50000, 1'b0);
    send(64'h70000, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'd12);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
